mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
Game-sequencing controller for the whack-a-mole datapath. It runs the game state machine, decides when and where moles appear on the 8 LEDs, times each mole's lifetime, scores hits from switch-toggle pulses, and ends the round on timeout. It sits between the LFSR/switch-toggle logic and the BCD/7-segment display path, and replaces free-running LED randomness with scheduled moles.

Parameters:
NUM_HOLES, 8, number of LEDs/switches (power of 2)
MAX_ACTIVE, 3, maximum simultaneously lit moles
LIFE_TICKS, 50, ticks a mole stays lit before escaping
SPAWN_TICKS, 20, ticks between spawn attempts
COUNT_TICKS, 200, countdown length before play
ROUND_TICKS, 3000, play duration in ticks
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-clk game-rate enable pulse
start  in  1  level; sampled each clk
rnd  in  log2(NUM_HOLES)  random hole index from LFSR
hit  in  NUM_HOLES  one-clk toggle pulses per switch
mole  out  NUM_HOLES  LED drive, 1 = mole lit
score  out  SCORE_W  hits scored, saturating
escaped  out  8  moles that expired unhit, saturating
time_left  out  12  remaining play ticks
state  out  2  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 OVER
game_over  out  1  high in OVER

Behaviour:
- Reset (rst low, async): state=IDLE; mole=0; score=0; escaped=0; time_left=0; game_over=0; all internal timers 0.
- IDLE: start=1 -> COUNTDOWN with countdown timer=COUNT_TICKS-1, score and escaped cleared.
- COUNTDOWN: timer decrements on tick; on tick with timer=0 -> PLAY, time_left=ROUND_TICKS, spawn timer=0. mole stays 0.
- PLAY: on each tick, time_left decrements. On the tick where time_left is 1, the state moves to OVER and time_left becomes 0. On entry to OVER, mole is cleared, and score/escaped freeze.
- OVER: game_over=1; start=1 -> COUNTDOWN (same clears as from IDLE). start is ignored in COUNTDOWN and PLAY.
- Spawn (PLAY, tick only): spawn timer counts 0..SPAWN_TICKS-1.
  - At terminal count, if the number of active moles is below MAX_ACTIVE, pick hole rnd. If that hole is occupied, probe rnd+1, rnd+2, ... modulo NUM_HOLES for the first free hole.
  - Set its mole bit, load its life counter with LIFE_TICKS-1, and reset the spawn timer to 0.
  - If active count equals MAX_ACTIVE, the spawn timer holds at terminal, and spawn occurs on the first tick after a slot frees.
  - The mole is visible the clk after the spawning tick.
- Lifetime (tick only): each lit hole's counter decrements. A lit hole with counter 0 on a tick clears and increments escaped, saturating at 255.
- Hits are evaluated every clk in PLAY, not tick-gated:
  - Each i with hit[i] & mole[i] clears mole[i].
  - score += popcount of such hits, saturating at 2^SCORE_W-1.
  - score updates 1 clk after the hit pulse.
- Simultaneous events:
  - Hit and expiry on the same hole and same clk: hit wins (score, no escape).
  - Hit on a hole that spawns in the same clk: the hit is ignored for the new mole, and the spawn uses occupancy before the hit.
  - Round end and hit in the same clk: the hit is scored, then the state moves to OVER.
  - Multiple hits in one clk all count.
- hit outside PLAY is ignored.
- Reset mid-round aborts immediately to the IDLE reset values.

Optional Feature:
MOLE_MISS_PENALTY_EN
- Defined: in PLAY, each hit[i] on an unlit hole decrements score by 1, floored at 0. If scoring hits and penalties occur in the same clk, score = sat(score + hits − misses), floored at 0.
- Undefined: hits on unlit holes are ignored; the logic is not compiled.

Decomposition:
- Package mole_pkg: state encoding (IDLE/COUNTDOWN/PLAY/OVER), HOLE_IDX_W=log2(NUM_HOLES), and popcount and saturating-add functions.
- Sub-module mole_slot: one per hole. It holds the lit flag and life counter, takes spawn/hit/tick/clear inputs, and returns lit, a one-clk scored pulse, and a one-clk escaped pulse. Instantiated NUM_HOLES times; the top level does arbitration, the spawn probe and the counters.

Test Plan:
- Reset/start: rst low mid-PLAY with mole=8'h05, score=7 -> immediately state=0, mole=0, score=0. Release, start=1 -> COUNTDOWN, then PLAY after 200 ticks with time_left=3000.
- Spawn and probe: COUNT_TICKS=2, SPAWN_TICKS=2. In PLAY, rnd=3 -> mole=8'h08. rnd=3 again -> 8'h18. rnd=7 with holes 7 and 0 lit -> bit 1 is set.
- Capacity: with 3 moles lit, no spawn regardless of rnd. Hit one lit hole -> score+1, and a new mole appears on the next tick.
- Expiry versus hit: LIFE_TICKS=3 gives escaped=1 after 3 ticks unhit. A hit pulse in the same clk as the expiry tick -> score+1, escaped unchanged.
- Multi-hit/saturation: hit=8'hFF with mole=8'h13 -> score+3, mole=0. Score preloaded near 255 saturates at 255.
- Round end/penalty: ROUND_TICKS=10 -> OVER after 10 play ticks with mole=0, and hits are then ignored. With MOLE_MISS_PENALTY_EN, score=1 and a hit on an empty hole -> 0, and a further miss keeps it at 0.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole scheduler: game-state encoding,
// the hole index width, and popcount / saturating-add helpers.
package mole_pkg;

    localparam int HOLES      = 8;
    localparam int HOLE_IDX_W = $clog2(HOLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        OVER      = 2'd3
    } game_state_t;

    function automatic logic [7:0] popcount(input logic [31:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // Adds a and b, clamping at max instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [15:0] max);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[15:0];
    endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole hole: lit flag plus life counter. Reports a same-clk scored pulse
// (hit on a lit hole) and escaped pulse (life ran out with no hit).
module mole_slot #(
    parameter int LIFE_TICKS = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic spawn,
    input  logic hit,
    input  logic clear,
    output logic lit,
    output logic scored,
    output logic escaped
);

    localparam int LW = (LIFE_TICKS > 1) ? $clog2(LIFE_TICKS) : 1;
    localparam logic [LW-1:0] LIFE_LOAD = LW'(LIFE_TICKS - 1);

    logic [LW-1:0] life;

    // A hit on the expiry tick takes priority, so escape is masked by hit.
    assign scored  = lit & hit;
    assign escaped = lit & tick & ~hit & (life == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lit  <= 1'b0;
            life <= '0;
        end else if (clear) begin
            lit  <= 1'b0;
            life <= '0;
        end else if (spawn) begin
            lit  <= 1'b1;
            life <= LIFE_LOAD;
        end else if (scored || escaped) begin
            lit  <= 1'b0;
            life <= '0;
        end else if (lit && tick) begin
            life <= life - LW'(1);
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: state machine, mole spawning, scoring and round
// timing. Optional MOLE_MISS_PENALTY_EN makes hits on unlit holes cost a point.
module mole_scheduler #(
    parameter int NUM_HOLES   = mole_pkg::HOLES,
    parameter int MAX_ACTIVE  = 3,
    parameter int LIFE_TICKS  = 50,
    parameter int SPAWN_TICKS = 20,
    parameter int COUNT_TICKS = 200,
    parameter int ROUND_TICKS = 3000,
    parameter int SCORE_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         start,
    input  logic [$clog2(NUM_HOLES)-1:0] rnd,
    input  logic [NUM_HOLES-1:0]         hit,
    output logic [NUM_HOLES-1:0]         mole,
    output logic [SCORE_W-1:0]           score,
    output logic [7:0]                   escaped,
    output logic [11:0]                  time_left,
    output logic [1:0]                   state,
    output logic                         game_over
);

    import mole_pkg::*;

    localparam int HW = $clog2(NUM_HOLES);
    localparam int CW = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
    localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam logic [CW-1:0] CD_LOAD    = CW'(COUNT_TICKS - 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_TICKS - 1);
    localparam logic [15:0]   SCORE_MAX  = 16'((1 << SCORE_W) - 1);

    game_state_t          state_q, state_d;
    logic [CW-1:0]        cd_q;
    logic [SW-1:0]        spawn_q;
    logic                 start_game, cd_done, round_end;
    logic                 in_play, play_tick, slot_clear, do_spawn, found;
    logic [NUM_HOLES-1:0] hit_play, spawn_vec, scored_vec, escaped_vec;
    logic [HW-1:0]        probe;
    logic [7:0]           active, hit_cnt, esc_cnt, esc_d;
    logic [SCORE_W-1:0]   score_d;
`ifdef MOLE_MISS_PENALTY_EN
    logic [7:0]           miss_cnt;
    logic signed [17:0]   net;
`endif

    assign in_play    = (state_q == PLAY);
    assign play_tick  = tick & in_play;
    assign hit_play   = hit & {NUM_HOLES{in_play}};
    assign slot_clear = ~in_play | round_end;
    assign active     = popcount(32'(mole));
    assign hit_cnt    = popcount(32'(scored_vec));
    assign esc_cnt    = popcount(32'(escaped_vec));
    assign esc_d      = 8'(sat_add(16'(escaped), {8'd0, esc_cnt}, 16'd255));
    assign state      = state_q;
    assign game_over  = (state_q == OVER);

    // Capacity is judged on occupancy before this clk's hits and expiries.
    assign do_spawn = play_tick && (spawn_q == SPAWN_LAST) && (active < 8'(MAX_ACTIVE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_game = 1'b0;
        cd_done    = 1'b0;
        round_end  = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d    = COUNTDOWN;
                    start_game = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (tick && cd_q == '0) begin
                    state_d = PLAY;
                    cd_done = 1'b1;
                end
            end
            PLAY: begin
                if (tick && time_left == 12'd1) begin
                    state_d   = OVER;
                    round_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Linear probe from rnd for the first hole that is currently dark.
    always_comb begin
        spawn_vec = '0;
        found     = 1'b0;
        probe     = rnd;
        for (int k = 0; k < NUM_HOLES; k++) begin
            probe = rnd + HW'(k);
            if (!found && !mole[probe]) begin
                found            = 1'b1;
                spawn_vec[probe] = do_spawn;
            end
        end
    end

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_slot
        mole_slot #(
            .LIFE_TICKS(LIFE_TICKS)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .tick   (play_tick),
            .spawn  (spawn_vec[i]),
            .hit    (hit_play[i]),
            .clear  (slot_clear),
            .lit    (mole[i]),
            .scored (scored_vec[i]),
            .escaped(escaped_vec[i])
        );
    end

    always_comb begin
        score_d = SCORE_W'(sat_add(16'(score), {8'd0, hit_cnt}, SCORE_MAX));
`ifdef MOLE_MISS_PENALTY_EN
        miss_cnt = popcount(32'(hit_play & ~mole));
        net = $signed({2'b00, 16'(score)}) + $signed({10'd0, hit_cnt})
            - $signed({10'd0, miss_cnt});
        if (net < 0) begin
            score_d = '0;
        end else if (net > $signed({2'b00, SCORE_MAX})) begin
            score_d = SCORE_W'(SCORE_MAX);
        end else begin
            score_d = SCORE_W'(net);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cd_q      <= '0;
            spawn_q   <= '0;
            time_left <= '0;
        end else begin
            if (start_game) begin
                cd_q <= CD_LOAD;
            end else if (state_q == COUNTDOWN && tick && cd_q != '0) begin
                cd_q <= cd_q - CW'(1);
            end
            if (cd_done) begin
                time_left <= 12'(ROUND_TICKS);
                spawn_q   <= '0;
            end else if (play_tick) begin
                time_left <= round_end ? 12'd0 : time_left - 12'd1;
                if (spawn_q != SPAWN_LAST) begin
                    spawn_q <= spawn_q + SW'(1);
                end else if (do_spawn) begin
                    spawn_q <= '0;
                end
            end
        end
    end

    // Score and escape counts freeze outside PLAY and clear on each new game.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score   <= '0;
            escaped <= '0;
        end else if (start_game) begin
            score   <= '0;
            escaped <= '0;
        end else if (in_play) begin
            score   <= score_d;
            escaped <= esc_d;
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: a hand-derived vector table for the
// corner cases, then randomized play checked against a behavioural game model.
module tb_mole_scheduler;

    localparam int NH        = 8;
    localparam int MAX_ACT   = 3;
    localparam int LIFE      = 7;
    localparam int SPAWN     = 2;
    localparam int COUNT     = 2;
    localparam int ROUND     = 40;
    localparam int SW        = 4;
    localparam int SCORE_MAX = (1 << SW) - 1;
`ifdef MOLE_MISS_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    rnd = '0;
    logic [NH-1:0] hit = '0;
    logic [NH-1:0] mole;
    logic [SW-1:0] score;
    logic [7:0]    escaped;
    logic [11:0]   time_left;
    logic [1:0]    state;
    logic          game_over;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       start;
        logic       tick;
        logic [2:0] rnd;
        logic [7:0] hit;
        int         st;
        int         mole;
        int         tl;
        int         sc;
        int         esc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int m_state, m_cd, m_tl, m_sp, m_score, m_esc;
    bit m_lit[NH];
    int m_life[NH];

    mole_scheduler #(
        .NUM_HOLES  (NH),
        .MAX_ACTIVE (MAX_ACT),
        .LIFE_TICKS (LIFE),
        .SPAWN_TICKS(SPAWN),
        .COUNT_TICKS(COUNT),
        .ROUND_TICKS(ROUND),
        .SCORE_W    (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .rnd      (rnd),
        .hit      (hit),
        .mole     (mole),
        .score    (score),
        .escaped  (escaped),
        .time_left(time_left),
        .state    (state),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cd = 0; m_tl = 0; m_sp = 0; m_score = 0; m_esc = 0;
        for (int i = 0; i < NH; i++) begin
            m_lit[i]  = 1'b0;
            m_life[i] = 0;
        end
    endtask

    function automatic logic [NH-1:0] model_mole();
        logic [NH-1:0] v;
        v = '0;
        for (int i = 0; i < NH; i++) v[i] = m_lit[i];
        return v;
    endfunction

    // One clk of the game rules, applied to the inputs sampled at that edge.
    task automatic model_step(input logic s, input logic t, input logic [2:0] r,
                              input logic [NH-1:0] h);
        bit pre[NH];
        int active, hits, misses, escs, tot, idx;
        bit found;
        case (m_state)
            0, 3: if (s) begin
                m_state = 1; m_cd = COUNT - 1; m_score = 0; m_esc = 0;
            end
            1: if (t) begin
                if (m_cd == 0) begin
                    m_state = 2; m_tl = ROUND; m_sp = 0;
                end else begin
                    m_cd--;
                end
            end
            default: begin
                active = 0; hits = 0; misses = 0; escs = 0;
                for (int i = 0; i < NH; i++) begin
                    pre[i] = m_lit[i];
                    if (pre[i]) active++;
                end
                for (int i = 0; i < NH; i++) begin
                    if (h[i] && pre[i]) begin
                        hits++;
                        m_lit[i] = 1'b0;
                    end else if (h[i]) begin
                        misses++;
                    end
                end
                if (t) begin
                    for (int i = 0; i < NH; i++) begin
                        if (pre[i] && !h[i]) begin
                            if (m_life[i] == 0) begin
                                m_lit[i] = 1'b0;
                                escs++;
                            end else begin
                                m_life[i]--;
                            end
                        end
                    end
                    if (m_sp == SPAWN - 1) begin
                        if (active < MAX_ACT) begin
                            found = 1'b0;
                            for (int k = 0; k < NH; k++) begin
                                idx = (int'(r) + k) % NH;
                                if (!found && !pre[idx]) begin
                                    found        = 1'b1;
                                    m_lit[idx]   = 1'b1;
                                    m_life[idx]  = LIFE - 1;
                                end
                            end
                            m_sp = 0;
                        end
                    end else begin
                        m_sp++;
                    end
                    if (m_tl == 1) begin
                        m_tl = 0;
                        m_state = 3;
                        for (int i = 0; i < NH; i++) m_lit[i] = 1'b0;
                    end else begin
                        m_tl--;
                    end
                end
                tot = m_score + hits - (PENALTY ? misses : 0);
                if (tot > SCORE_MAX) tot = SCORE_MAX;
                if (tot < 0) tot = 0;
                m_score = tot;
                m_esc = (m_esc + escs > 255) ? 255 : m_esc + escs;
            end
        endcase
    endtask

    task automatic check_output(input string tag);
        check_val({tag, " mole"}, int'(mole), int'(model_mole()));
        check_val({tag, " score"}, int'(score), m_score);
        check_val({tag, " escaped"}, int'(escaped), m_esc);
        check_val({tag, " time_left"}, int'(time_left), m_tl);
        check_val({tag, " state"}, int'(state), m_state);
        check_val({tag, " game_over"}, int'(game_over), (m_state == 3) ? 1 : 0);
    endtask

    task automatic add_vec(input logic s, input logic t, input logic [2:0] r,
                           input logic [7:0] h, input int st, input int m,
                           input int tl, input int sc, input int esc);
        vec_t v;
        v.start = s; v.tick = t; v.rnd = r; v.hit = h;
        v.st = st; v.mole = m; v.tl = tl; v.sc = sc; v.esc = esc;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v, input int n);
        string tag;
        start = v.start; tick = v.tick; rnd = v.rnd; hit = v.hit;
        @(posedge clk);
        #1;
        tag = $sformatf("vec%0d", n);
        check_val({tag, " state"}, int'(state), v.st);
        check_val({tag, " mole"}, int'(mole), v.mole);
        check_val({tag, " time_left"}, int'(time_left), v.tl);
        check_val({tag, " score"}, int'(score), v.sc);
        check_val({tag, " escaped"}, int'(escaped), v.esc);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0; start = 1'b0; tick = 1'b0; hit = '0;
        #1;
        model_reset();
        check_output(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic random_cycle(input int n);
        logic [NH-1:0] lit_vec;
        if ($urandom_range(0, 399) == 0) async_reset($sformatf("rand_reset%0d", n));
        lit_vec = model_mole();
        start = ($urandom_range(0, 5) == 0);
        tick  = 1'($urandom_range(0, 1));
        rnd   = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       hit = lit_vec & NH'($urandom);
            1:       hit = NH'($urandom) & NH'($urandom);
            2:       hit = lit_vec;
            default: hit = '0;
        endcase
        @(posedge clk);
        model_step(start, tick, rnd, hit);
        #1;
        check_output($sformatf("rand%0d", n));
    endtask

    initial begin
        // start tick rnd hit | state mole time_left score escaped
        add_vec(1, 0, 0, 8'h00, 1, 8'h00,  0, 0, 0);
        add_vec(0, 1, 0, 8'h00, 1, 8'h00,  0, 0, 0);
        add_vec(0, 1, 0, 8'h00, 2, 8'h00, 40, 0, 0);
        add_vec(0, 1, 3, 8'h00, 2, 8'h00, 39, 0, 0);
        add_vec(0, 1, 3, 8'h00, 2, 8'h08, 38, 0, 0);
        add_vec(0, 1, 3, 8'h00, 2, 8'h08, 37, 0, 0);
        add_vec(0, 1, 3, 8'h00, 2, 8'h18, 36, 0, 0);
        add_vec(0, 1, 7, 8'h00, 2, 8'h18, 35, 0, 0);
        add_vec(0, 1, 7, 8'h00, 2, 8'h98, 34, 0, 0);
        add_vec(0, 1, 0, 8'h00, 2, 8'h98, 33, 0, 0);
        add_vec(0, 1, 0, 8'h00, 2, 8'h98, 32, 0, 0);
        add_vec(1, 0, 0, 8'h08, 2, 8'h90, 32, 1, 0);
        add_vec(0, 1, 3, 8'h00, 2, 8'h98, 31, 1, 0);
        add_vec(0, 0, 0, 8'h18, 2, 8'h80, 31, 3, 0);
        add_vec(0, 1, 0, 8'h00, 2, 8'h80, 30, 3, 0);
        add_vec(0, 1, 0, 8'h00, 2, 8'h81, 29, 3, 0);
        add_vec(0, 1, 7, 8'h00, 2, 8'h81, 28, 3, 0);
        add_vec(0, 1, 7, 8'h00, 2, 8'h03, 27, 3, 1);
        add_vec(0, 0, 0, 8'h03, 2, 8'h00, 27, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'h00, 26, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'h20, 25, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'h20, 24, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'h60, 23, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'h60, 22, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'hE0, 21, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'hE0, 20, 5, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'hE0, 19, 5, 1);
        add_vec(0, 1, 5, 8'h20, 2, 8'hC0, 18, 6, 1);
        add_vec(0, 1, 5, 8'h00, 2, 8'hE0, 17, 6, 1);

        model_reset();
        #12;
        check_output("power_on_reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

        // Abort mid-round with moles lit and a non-zero score.
        async_reset("mid_round_reset");

        for (int n = 0; n < 4000; n++) random_cycle(n);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
